// File: rtl/issue_scheduler_pkg.sv
// Shared types and helpers for the issue queue: FU select codes, issue-port
// enumeration, FU-to-port mapping and the per-entry storage layout.
package issue_pkg;

    localparam int IQ_DEPTH     = 8;
    localparam int IQ_NUM_WB    = 2;
    localparam int IQ_PREG_W    = 7;
    localparam int IQ_ROB_W     = 3;
    localparam int IQ_PAYLOAD_W = 96;
    localparam int NUM_PORTS    = 3;

    localparam logic [2:0] FU_ALU   = 3'd0;
    localparam logic [2:0] FU_MUL   = 3'd1;
    localparam logic [2:0] FU_DIV   = 3'd2;
    localparam logic [2:0] FU_FALU  = 3'd3;
    localparam logic [2:0] FU_FMUL  = 3'd4;
    localparam logic [2:0] FU_FDIV  = 3'd5;
    localparam logic [2:0] FU_LOAD  = 3'd6;
    localparam logic [2:0] FU_STORE = 3'd7;

    typedef enum logic [1:0] {
        PORT_INT = 2'd0,
        PORT_FP  = 2'd1,
        PORT_MEM = 2'd2
    } iq_port_e;

    function automatic iq_port_e fu_to_port(input logic [2:0] fu_sel);
        iq_port_e port;
        case (fu_sel)
            FU_ALU, FU_MUL, FU_DIV:    port = PORT_INT;
            FU_FALU, FU_FMUL, FU_FDIV: port = PORT_FP;
            FU_LOAD, FU_STORE:         port = PORT_MEM;
            default:                   port = PORT_INT;
        endcase
        return port;
    endfunction

    typedef struct packed {
        logic                    valid;
        logic                    rs1_rdy;
        logic                    rs2_rdy;
        logic [IQ_PREG_W-1:0]    p_rs1;
        logic [IQ_PREG_W-1:0]    p_rs2;
        logic [IQ_PREG_W-1:0]    p_rd;
        logic [2:0]              fu_sel;
        logic [IQ_ROB_W-1:0]     rob_idx;
        logic [IQ_PAYLOAD_W-1:0] payload;
    } iq_entry_t;

endpackage

// File: rtl/issue_scheduler_age_select.sv
// Oldest-first picker: grants the requesting entry that is older than every
// other requester, where i_age[i][j]=1 means entry i is older than entry j.
module iq_age_select #(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]            i_req,
    input  logic [DEPTH-1:0][DEPTH-1:0] i_age,
    output logic [DEPTH-1:0]            o_grant
);

    always_comb begin
        o_grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_grant[i] = i_req[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && i_req[j] && !i_age[i][j]) begin
                    o_grant[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/issue_scheduler.sv
// Unified issue queue: tracks operand readiness through writeback wakeups and
// issues the oldest ready micro-op on each of the INT, FP and MEM ports.
module issue_scheduler
    import issue_pkg::*;
#(
    parameter int DEPTH     = IQ_DEPTH,
    parameter int NUM_WB    = IQ_NUM_WB,
    parameter int PREG_W    = IQ_PREG_W,
    parameter int ROB_W     = IQ_ROB_W,
    parameter int PAYLOAD_W = IQ_PAYLOAD_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           disp_valid,
    output logic                           disp_ready,
    input  logic [PREG_W-1:0]              disp_P_rs1,
    input  logic [PREG_W-1:0]              disp_P_rs2,
    input  logic                           disp_rs1_rdy,
    input  logic                           disp_rs2_rdy,
    input  logic [PREG_W-1:0]              disp_P_rd,
    input  logic [2:0]                     disp_fu_sel,
    input  logic [ROB_W-1:0]               disp_rob_idx,
    input  logic [PAYLOAD_W-1:0]           disp_payload,
    input  logic [NUM_WB-1:0]              wb_valid,
    input  logic [NUM_WB*PREG_W-1:0]       wb_tag,
    input  logic                           flush,
    output logic [NUM_PORTS-1:0]           iss_valid,
    input  logic [NUM_PORTS-1:0]           iss_ready,
    output logic [NUM_PORTS*PREG_W-1:0]    iss_P_rs1,
    output logic [NUM_PORTS*PREG_W-1:0]    iss_P_rs2,
    output logic [NUM_PORTS*PREG_W-1:0]    iss_P_rd,
    output logic [NUM_PORTS*3-1:0]         iss_fu_sel,
    output logic [NUM_PORTS*ROB_W-1:0]     iss_rob_idx,
    output logic [NUM_PORTS*PAYLOAD_W-1:0] iss_payload,
    output logic [$clog2(DEPTH):0]         count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    iq_entry_t [DEPTH-1:0]           r_entries;
    logic [DEPTH-1:0][DEPTH-1:0]     r_age;
    logic [CNT_W-1:0]                r_count;

    logic [NUM_PORTS-1:0][DEPTH-1:0] w_req;
    logic [NUM_PORTS-1:0][DEPTH-1:0] w_grant;
    logic [DEPTH-1:0]                w_free;
    logic [CNT_W-1:0]                w_num_free;
    logic                            w_disp_fire;
    logic [IDX_W-1:0]                w_alloc_idx;
    logic                            w_disp_rs1_rdy;
    logic                            w_disp_rs2_rdy;

    // disp_ready looks only at the registered count, so same-cycle frees are invisible
    assign disp_ready  = (r_count < CNT_W'(DEPTH));
    assign w_disp_fire = disp_valid && disp_ready && !flush;
    assign count       = r_count;

    always_comb begin
        w_req = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (r_entries[i].valid && r_entries[i].rs1_rdy && r_entries[i].rs2_rdy
                    && fu_to_port(r_entries[i].fu_sel) == 2'(p)) begin
                    w_req[p][i] = 1'b1;
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_sel
        iq_age_select #(.DEPTH(DEPTH)) u_age_select (
            .i_req   (w_req[p]),
            .i_age   (r_age),
            .o_grant (w_grant[p])
        );
    end

    always_comb begin
        iss_valid   = '0;
        iss_P_rs1   = '0;
        iss_P_rs2   = '0;
        iss_P_rd    = '0;
        iss_fu_sel  = '0;
        iss_rob_idx = '0;
        iss_payload = '0;
        w_free      = '0;
        w_num_free  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            iss_valid[p] = |w_req[p];
            for (int i = 0; i < DEPTH; i++) begin
                if (w_grant[p][i]) begin
                    iss_P_rs1[p*PREG_W +: PREG_W]       = r_entries[i].p_rs1;
                    iss_P_rs2[p*PREG_W +: PREG_W]       = r_entries[i].p_rs2;
                    iss_P_rd[p*PREG_W +: PREG_W]        = r_entries[i].p_rd;
                    iss_fu_sel[p*3 +: 3]                = r_entries[i].fu_sel;
                    iss_rob_idx[p*ROB_W +: ROB_W]       = r_entries[i].rob_idx;
                    iss_payload[p*PAYLOAD_W +: PAYLOAD_W] = r_entries[i].payload;
                end
            end
            if (iss_valid[p] && iss_ready[p]) begin
                w_free     = w_free | w_grant[p];
                w_num_free = w_num_free + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_entries[i].valid) begin
                w_alloc_idx = IDX_W'(i);
            end
        end
    end

    // Tag 0 is hardwired ready; a same-cycle writeback also counts as ready
    always_comb begin
        w_disp_rs1_rdy = disp_rs1_rdy || (disp_P_rs1 == '0);
        w_disp_rs2_rdy = disp_rs2_rdy || (disp_P_rs2 == '0);
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid[k] && wb_tag[k*PREG_W +: PREG_W] == disp_P_rs1) begin
                w_disp_rs1_rdy = 1'b1;
            end
            if (wb_valid[k] && wb_tag[k*PREG_W +: PREG_W] == disp_P_rs2) begin
                w_disp_rs2_rdy = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_entries <= '0;
            r_age     <= '0;
            r_count   <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i].valid <= 1'b0;
            end
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_free[i]) begin
                    r_entries[i].valid <= 1'b0;
                end else if (r_entries[i].valid) begin
                    for (int k = 0; k < NUM_WB; k++) begin
                        if (wb_valid[k] && wb_tag[k*PREG_W +: PREG_W] == r_entries[i].p_rs1) begin
                            r_entries[i].rs1_rdy <= 1'b1;
                        end
                        if (wb_valid[k] && wb_tag[k*PREG_W +: PREG_W] == r_entries[i].p_rs2) begin
                            r_entries[i].rs2_rdy <= 1'b1;
                        end
                    end
                end
            end
            // New entry is youngest: every live entry becomes older than it
            if (w_disp_fire) begin
                r_entries[w_alloc_idx] <= '{
                    valid:   1'b1,
                    rs1_rdy: w_disp_rs1_rdy,
                    rs2_rdy: w_disp_rs2_rdy,
                    p_rs1:   disp_P_rs1,
                    p_rs2:   disp_P_rs2,
                    p_rd:    disp_P_rd,
                    fu_sel:  disp_fu_sel,
                    rob_idx: disp_rob_idx,
                    payload: disp_payload
                };
                for (int r = 0; r < DEPTH; r++) begin
                    r_age[r][w_alloc_idx] <= r_entries[r].valid;
                end
                r_age[w_alloc_idx] <= '0;
            end
            r_count <= r_count + CNT_W'(w_disp_fire) - w_num_free;
        end
    end

endmodule
